ddr_burst_reader: RTL and testbench

- Downstream of fill_fifo_fsm; consumes its go_fill_fifo pulse and ddr_addr_to_read address.
- Issues one fixed-length PLB master burst read per request through the IPIF master interface.
- Streams the returned words into the HDMI pixel FIFO, honouring FIFO backpressure.
- Reports busy, overrun and bus-error status to user_logic slave registers.

---
 rtl/ddr_burst_reader_if.sv | 38 +++
 rtl/ddr_burst_reader.sv | 136 +++++++++++++
 tb/tb_ddr_burst_reader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_burst_reader_if.sv
// IPIF master read-channel bundle between ddr_burst_reader and the PLB master IPIF.
//   master modport : the burst reader side (drives command and dst_rdy_n)
//   slave modport  : the IPIF side (drives acks, completion and read data)
interface ddr_burst_reader_if;
  logic        IP2Bus_MstRd_Req;
  logic [31:0] IP2Bus_Mst_Addr;
  logic [11:0] IP2Bus_Mst_Length;
  logic        Bus2IP_Mst_CmdAck;
  logic        Bus2IP_Mst_Cmplt;
  logic        Bus2IP_Mst_Error;
  logic [31:0] Bus2IP_MstRd_d;
  logic        Bus2IP_MstRd_src_rdy_n;
  logic        IP2Bus_MstRd_dst_rdy_n;

  modport master (
    output IP2Bus_MstRd_Req,
    output IP2Bus_Mst_Addr,
    output IP2Bus_Mst_Length,
    input  Bus2IP_Mst_CmdAck,
    input  Bus2IP_Mst_Cmplt,
    input  Bus2IP_Mst_Error,
    input  Bus2IP_MstRd_d,
    input  Bus2IP_MstRd_src_rdy_n,
    output IP2Bus_MstRd_dst_rdy_n
  );

  modport slave (
    input  IP2Bus_MstRd_Req,
    input  IP2Bus_Mst_Addr,
    input  IP2Bus_Mst_Length,
    output Bus2IP_Mst_CmdAck,
    output Bus2IP_Mst_Cmplt,
    output Bus2IP_Mst_Error,
    output Bus2IP_MstRd_d,
    output Bus2IP_MstRd_src_rdy_n,
    input  IP2Bus_MstRd_dst_rdy_n
  );
endinterface

// File: rtl/ddr_burst_reader.sv
// Fixed-length PLB master burst reader feeding the HDMI pixel FIFO.
// On a go_fill_fifo pulse in idle it issues one BURST_BYTES read through the
// IPIF master interface and streams the returned words into the pixel FIFO,
// honouring fifo_full backpressure.
// Ports:
//   Bus2IP_Clk, Bus2IP_Reset : clock, asynchronous active-high reset
//   reset_fill_fifo          : synchronous soft abort (drains an open transfer)
//   go_fill_fifo             : single-cycle request, ddr_addr_to_read sampled with it
//   bus                      : IPIF master read channel (master modport)
//   fifo_full/wr_en/wr_data  : pixel FIFO write port
//   busy, overrun, bus_err   : status to user_logic (overrun/bus_err sticky)
module ddr_burst_reader #(
  parameter int unsigned BURST_BYTES = 256
) (
  input  logic                 Bus2IP_Clk,
  input  logic                 Bus2IP_Reset,
  input  logic                 reset_fill_fifo,
  input  logic                 go_fill_fifo,
  input  logic [31:0]          ddr_addr_to_read,
  ddr_burst_reader_if.master   bus,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [31:0]          fifo_wr_data,
  output logic                 busy,
  output logic                 overrun,
  output logic                 bus_err
);

  localparam int unsigned BEATS = BURST_BYTES / 4;
  localparam int unsigned CntW  = $clog2(BEATS + 1);

  typedef enum logic [1:0] {StIdle, StReq, StData, StWaitCmplt} state_e;

  state_e            state;
  logic              rd_req;
  logic [31:0]       addr_q;
  logic [CntW-1:0]   beat_cnt;
  logic              drain;
  logic              overrun_q;
  logic              bus_err_q;

  logic              dst_rdy_n;
  logic              beat;
  logic              last_beat;
  logic              cmplt;
  logic              err_cmplt;

  assign cmplt     = bus.Bus2IP_Mst_Cmplt;
  assign err_cmplt = bus.Bus2IP_Mst_Cmplt & bus.Bus2IP_Mst_Error;

  // While draining (or on the abort cycle itself) beats are swallowed so the
  // IPIF can finish; otherwise only DATA accepts and FIFO backpressure applies.
  always_comb begin
    dst_rdy_n = 1'b1;
    if (state == StData || state == StWaitCmplt) begin
      if (drain || reset_fill_fifo) begin
        dst_rdy_n = 1'b0;
      end else if (state == StData) begin
        dst_rdy_n = fifo_full;
      end
    end
  end

  assign beat      = (state == StData) & ~bus.Bus2IP_MstRd_src_rdy_n & ~dst_rdy_n;
  assign fifo_wr_en = beat & ~drain & ~reset_fill_fifo;
  assign last_beat = fifo_wr_en & (beat_cnt == CntW'(BEATS - 1));

  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) begin
      state     <= StIdle;
      rd_req    <= 1'b0;
      addr_q    <= '0;
      beat_cnt  <= '0;
      drain     <= 1'b0;
      overrun_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (go_fill_fifo && state != StIdle) overrun_q <= 1'b1;
      if (err_cmplt) bus_err_q <= 1'b1;
      // Soft abort clears the sticky flags, overriding any set this cycle.
      if (reset_fill_fifo) begin
        overrun_q <= 1'b0;
        bus_err_q <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (go_fill_fifo && !reset_fill_fifo) begin
            addr_q   <= ddr_addr_to_read & 32'hFFFF_FFFC;
            beat_cnt <= '0;
            rd_req   <= 1'b1;
            state    <= StReq;
          end
        end
        StReq: begin
          if (reset_fill_fifo || err_cmplt) begin
            rd_req <= 1'b0;
            state  <= StIdle;
          end else if (bus.Bus2IP_Mst_CmdAck) begin
            rd_req <= 1'b0;
            state  <= StData;
          end
        end
        StData: begin
          if (fifo_wr_en) beat_cnt <= beat_cnt + 1'b1;
          if (reset_fill_fifo) drain <= 1'b1;
          // Any completion (early, errored or coincident with the last beat) ends the burst.
          if (cmplt) begin
            drain <= 1'b0;
            state <= StIdle;
          end else if (last_beat) begin
            state <= StWaitCmplt;
          end
        end
        StWaitCmplt: begin
          if (reset_fill_fifo) drain <= 1'b1;
          if (cmplt) begin
            drain <= 1'b0;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.IP2Bus_MstRd_Req       = rd_req;
  assign bus.IP2Bus_Mst_Addr        = addr_q;
  assign bus.IP2Bus_Mst_Length      = 12'(BURST_BYTES);
  assign bus.IP2Bus_MstRd_dst_rdy_n = dst_rdy_n;
  assign fifo_wr_data               = bus.Bus2IP_MstRd_d;
  assign busy                       = (state != StIdle);
  assign overrun                    = overrun_q;
  assign bus_err                    = bus_err_q;

endmodule

// File: tb/tb_ddr_burst_reader.sv
module tb_ddr_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rff;
  logic        go;
  logic [31:0] addr;
  logic        fifo_full;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        busy;
  logic        overrun;
  logic        bus_err;

  ddr_burst_reader_if bus ();

  ddr_burst_reader dut (
    .Bus2IP_Clk       (clk),
    .Bus2IP_Reset     (rst),
    .reset_fill_fifo  (rff),
    .go_fill_fifo     (go),
    .ddr_addr_to_read (addr),
    .bus              (bus),
    .fifo_full        (fifo_full),
    .fifo_wr_en       (wr_en),
    .fifo_wr_data     (wr_data),
    .busy             (busy),
    .overrun          (overrun),
    .bus_err          (bus_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int seqv     = 0;
  int wr_cnt   = 0;
  logic [31:0] wr_log [0:511];

  always @(posedge clk) begin
    if (wr_en === 1'b1) begin
      if (wr_cnt < 512) wr_log[wr_cnt] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Request a burst and acknowledge after ack_delay cycles of Req.
  task automatic start_burst(input logic [31:0] a, input logic [31:0] exp_a, input int ack_delay);
    go   = 1'b1;
    addr = a;
    tick();
    go   = 1'b0;
    for (int i = 0; i < ack_delay; i++) begin
      chk1("req_held", bus.IP2Bus_MstRd_Req, 1'b1);
      tick();
    end
    chk1("req_before_ack", bus.IP2Bus_MstRd_Req, 1'b1);
    chk32("addr", bus.IP2Bus_Mst_Addr, exp_a);
    chk32("length", 32'(bus.IP2Bus_Mst_Length), 32'd256);
    chk1("busy_req", busy, 1'b1);
    bus.Bus2IP_Mst_CmdAck = 1'b1;
    tick();
    bus.Bus2IP_Mst_CmdAck = 1'b0;
    chk1("req_after_ack", bus.IP2Bus_MstRd_Req, 1'b0);
  endtask

  // Offer n beats back-to-back; fifo_full high for cycles [full_at, full_at+full_len).
  task automatic stream(input int n, input int full_at, input int full_len, input bit cmplt_last);
    int acc = 0;
    int cyc = 0;
    while (acc < n && cyc < 400) begin
      fifo_full = (cyc >= full_at && cyc < full_at + full_len);
      bus.Bus2IP_MstRd_src_rdy_n = 1'b0;
      bus.Bus2IP_MstRd_d = 32'hC0DE_0000 + 32'(seqv);
      bus.Bus2IP_Mst_Cmplt = cmplt_last && (acc == n - 1) && !fifo_full;
      #1;
      chk1("dst_rdy_n", bus.IP2Bus_MstRd_dst_rdy_n, fifo_full);
      chk1("wr_en_beat", wr_en, !fifo_full);
      tick();
      if (!fifo_full) begin
        acc++;
        seqv++;
      end
      cyc++;
    end
    if (acc < n) chk32("stream_timeout", 32'(acc), 32'(n));
    bus.Bus2IP_MstRd_src_rdy_n = 1'b1;
    bus.Bus2IP_Mst_Cmplt = 1'b0;
    fifo_full = 1'b0;
  endtask

  initial begin
    int st;
    bit ok;
    rst = 1'b1;
    rff = 1'b0;
    go = 1'b0;
    addr = '0;
    fifo_full = 1'b0;
    bus.Bus2IP_Mst_CmdAck = 1'b0;
    bus.Bus2IP_Mst_Cmplt = 1'b0;
    bus.Bus2IP_Mst_Error = 1'b0;
    bus.Bus2IP_MstRd_d = '0;
    bus.Bus2IP_MstRd_src_rdy_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_req", bus.IP2Bus_MstRd_Req, 1'b0);
    chk1("rst_dst_rdy_n", bus.IP2Bus_MstRd_dst_rdy_n, 1'b1);
    chk32("rst_addr", bus.IP2Bus_Mst_Addr, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_overrun", overrun, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    chk1("rst_wr_en", wr_en, 1'b0);
    rst = 1'b0;
    tick();

    // Basic 64-beat burst, CmdAck after 3 cycles, Cmplt later.
    st = wr_cnt;
    start_burst(32'h1000_0003, 32'h1000_0000, 3);
    stream(64, 1000, 0, 1'b0);
    chk1("wait_busy", busy, 1'b1);
    chk1("wait_dst_rdy_n", bus.IP2Bus_MstRd_dst_rdy_n, 1'b1);
    bus.Bus2IP_Mst_Cmplt = 1'b1;
    tick();
    bus.Bus2IP_Mst_Cmplt = 1'b0;
    chk1("done_busy", busy, 1'b0);
    chk32("writes_basic", 32'(wr_cnt - st), 32'd64);

    // Backpressure for 5 cycles, then 4 cycles in WAIT_CMPLT with stray beats.
    st = wr_cnt;
    start_burst(32'h2000_0100, 32'h2000_0100, 0);
    stream(64, 10, 5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.Bus2IP_MstRd_src_rdy_n = 1'b0;
      bus.Bus2IP_MstRd_d = 32'hDEAD_BEEF;
      #1;
      chk1("wait_no_wr", wr_en, 1'b0);
      chk1("wait_dst_hi", bus.IP2Bus_MstRd_dst_rdy_n, 1'b1);
      chk1("wait_busy4", busy, 1'b1);
      tick();
    end
    bus.Bus2IP_MstRd_src_rdy_n = 1'b1;
    bus.Bus2IP_Mst_Cmplt = 1'b1;
    tick();
    bus.Bus2IP_Mst_Cmplt = 1'b0;
    chk1("bp_done_busy", busy, 1'b0);
    chk32("writes_bp", 32'(wr_cnt - st), 32'd64);

    // Cmplt coincident with beat 64: straight back to idle.
    st = wr_cnt;
    start_burst(32'h3000_0002, 32'h3000_0000, 1);
    stream(64, 1000, 0, 1'b1);
    chk1("coinc_busy", busy, 1'b0);
    chk1("coinc_dst_rdy_n", bus.IP2Bus_MstRd_dst_rdy_n, 1'b1);
    chk32("writes_coinc", 32'(wr_cnt - st), 32'd64);

    // Overrun during DATA, then errored completion after beat 10.
    st = wr_cnt;
    start_burst(32'h4000_0000, 32'h4000_0000, 0);
    stream(5, 1000, 0, 1'b0);
    go = 1'b1;
    addr = 32'h5555_5554;
    tick();
    go = 1'b0;
    chk1("overrun_set", overrun, 1'b1);
    chk1("no_second_req", bus.IP2Bus_MstRd_Req, 1'b0);
    stream(5, 1000, 0, 1'b0);
    chk1("no_err_yet", bus_err, 1'b0);
    bus.Bus2IP_Mst_Cmplt = 1'b1;
    bus.Bus2IP_Mst_Error = 1'b1;
    tick();
    bus.Bus2IP_Mst_Cmplt = 1'b0;
    bus.Bus2IP_Mst_Error = 1'b0;
    chk1("bus_err_set", bus_err, 1'b1);
    chk1("err_idle", busy, 1'b0);
    chk1("err_req_low", bus.IP2Bus_MstRd_Req, 1'b0);
    chk32("writes_err", 32'(wr_cnt - st), 32'd10);

    // Soft abort at beat 20: drain without writing, flags cleared.
    st = wr_cnt;
    start_burst(32'h6000_0000, 32'h6000_0000, 2);
    stream(20, 1000, 0, 1'b0);
    chk1("flags_before_rff", overrun & bus_err, 1'b1);
    rff = 1'b1;
    bus.Bus2IP_MstRd_src_rdy_n = 1'b0;
    bus.Bus2IP_MstRd_d = 32'hBAD0_0000;
    #1;
    chk1("rff_no_wr", wr_en, 1'b0);
    chk1("rff_dst_lo", bus.IP2Bus_MstRd_dst_rdy_n, 1'b0);
    tick();
    rff = 1'b0;
    chk1("rff_clr_overrun", overrun, 1'b0);
    chk1("rff_clr_bus_err", bus_err, 1'b0);
    for (int i = 0; i < 10; i++) begin
      fifo_full = (i >= 3 && i < 6);
      #1;
      chk1("drain_no_wr", wr_en, 1'b0);
      chk1("drain_dst_lo", bus.IP2Bus_MstRd_dst_rdy_n, 1'b0);
      chk1("drain_busy", busy, 1'b1);
      tick();
    end
    fifo_full = 1'b0;
    bus.Bus2IP_MstRd_src_rdy_n = 1'b1;
    bus.Bus2IP_Mst_Cmplt = 1'b1;
    tick();
    bus.Bus2IP_Mst_Cmplt = 1'b0;
    chk1("drain_done", busy, 1'b0);
    chk32("writes_drain", 32'(wr_cnt - st), 32'd20);

    // Soft abort while in REQ.
    go = 1'b1;
    addr = 32'h7000_0000;
    tick();
    go = 1'b0;
    chk1("req2_high", bus.IP2Bus_MstRd_Req, 1'b1);
    rff = 1'b1;
    tick();
    rff = 1'b0;
    chk1("req_abort_low", bus.IP2Bus_MstRd_Req, 1'b0);
    chk1("req_abort_idle", busy, 1'b0);

    // Hard reset mid-REQ acts without a clock edge.
    go = 1'b1;
    addr = 32'h8000_0000;
    tick();
    go = 1'b0;
    chk1("req3_high", bus.IP2Bus_MstRd_Req, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("async_req_low", bus.IP2Bus_MstRd_Req, 1'b0);
    chk1("async_idle", busy, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    ok = 1'b1;
    for (int k = 0; k < wr_cnt && k < 512; k++) begin
      if (wr_log[k] !== 32'hC0DE_0000 + 32'(k)) ok = 1'b0;
    end
    chk1("data_sequence", ok, 1'b1);
    chk32("total_writes", 32'(wr_cnt), 32'(seqv));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
